// File: rtl/len_table_pkg.sv
//------------------------------------------------------------------------------
// len_table_pkg : per-case micro-op expansion tables
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package len_table_pkg;

  localparam int MAX_LEN = 8;
  localparam int N_CASE  = 5;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_INC  = 4'd6,
    OP_DEC  = 4'd7,
    OP_IMUL = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10
  } op_t;

  // Packed tables: the rightmost element is case 0.
  localparam logic [N_CASE-1:0][7:0] LEN_LUT   = {8'd0, 8'd3, 8'd2, 8'd2, 8'd2};
  localparam logic [N_CASE-1:0][7:0] STAGE_LUT = {8'd1, 8'd0, 8'd1, 8'd1, 8'd1};

  localparam logic [N_CASE-1:0][MAX_LEN-1:0] FF_MASK_LUT =
    {8'b0000_0000, 8'b0000_0110, 8'b0000_0010, 8'b0000_0010, 8'b0000_0010};
  localparam logic [N_CASE-1:0][MAX_LEN-1:0] USE_IMM_LUT =
    {8'b0000_0000, 8'b0000_0100, 8'b0000_0000, 8'b0000_0011, 8'b0000_0001};

  localparam op_t OPS_LUT [N_CASE][MAX_LEN] = '{
    '{0: OP_IMUL, 1: OP_ADD, default: OP_NOP},
    '{0: OP_AND,  1: OP_AND, default: OP_NOP},
    '{0: OP_DEC,  1: OP_SUB, default: OP_NOP},
    '{0: OP_INC,  1: OP_INC, 2: OP_XOR, default: OP_NOP},
    '{default: OP_NOP}
  };

  localparam logic [31:0] IMM_LUT [N_CASE][MAX_LEN] = '{
    '{0: 32'd7, default: 32'd0},
    '{0: 32'h0000_00FF, 1: 32'h0000_00F0, default: 32'd0},
    '{default: 32'd0},
    '{2: 32'h5A5A_0000, default: 32'd0},
    '{default: 32'd0}
  };

endpackage

`default_nettype wire

// File: rtl/uop_sequencer_if.sv
//------------------------------------------------------------------------------
// uop_sequencer_if : request, micro-op and completion channels of the sequencer
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uop_sequencer_if #(
  parameter int CASE_W = 3,
  parameter int TAG_W  = 4
);
  localparam int IDX_W = (len_table_pkg::MAX_LEN > 1) ? $clog2(len_table_pkg::MAX_LEN) : 1;

  logic                 req_valid;
  logic                 req_ready;
  logic [CASE_W-1:0]    req_case_id;
  logic [TAG_W-1:0]     req_tag;

  logic                 uop_valid;
  logic                 uop_ready;
  len_table_pkg::op_t   uop_op;
  logic [31:0]          uop_imm;
  logic                 uop_use_imm;
  logic                 uop_fwd;
  logic [IDX_W-1:0]     uop_idx;
  logic                 uop_last;
  logic [TAG_W-1:0]     uop_tag;

  logic                 done_valid;
  logic                 done_err;
  logic [TAG_W-1:0]     done_tag;

  modport master (
    output req_valid, req_case_id, req_tag, uop_ready,
    input  req_ready, uop_valid, uop_op, uop_imm, uop_use_imm, uop_fwd,
           uop_idx, uop_last, uop_tag, done_valid, done_err, done_tag
  );

  modport slave (
    input  req_valid, req_case_id, req_tag, uop_ready,
    output req_ready, uop_valid, uop_op, uop_imm, uop_use_imm, uop_fwd,
           uop_idx, uop_last, uop_tag, done_valid, done_err, done_tag
  );

endinterface

`default_nettype wire

// File: rtl/uop_sequencer.sv
//------------------------------------------------------------------------------
// uop_sequencer : expands an accepted macro-op case into its micro-op stream
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uop_sequencer #(
  parameter int CASE_W = 3,
  parameter int TAG_W  = 4,
  parameter logic [len_table_pkg::N_CASE-1:0][7:0] STAGE_TAB = len_table_pkg::STAGE_LUT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  uop_sequencer_if.slave bus
);
  import len_table_pkg::*;

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W = 8;
  localparam int LEN_W = IDX_W + 1;
  localparam int SEL_W = (N_CASE > 1) ? $clog2(N_CASE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_case;
  logic [TAG_W-1:0]   r_tag;
  logic [LEN_W-1:0]   r_len;
  logic [GAP_W-1:0]   r_stage;
  logic [GAP_W-1:0]   r_gap;
  logic [IDX_W-1:0]   r_idx;

  logic               r_uop_valid;
  op_t                r_uop_op;
  logic [31:0]        r_uop_imm;
  logic               r_uop_use_imm;
  logic               r_uop_fwd;
  logic [IDX_W-1:0]   r_uop_idx;
  logic               r_uop_last;
  logic [TAG_W-1:0]   r_uop_tag;
  logic               r_done_valid;
  logic               r_done_err;
  logic [TAG_W-1:0]   r_done_tag;

  logic [31:0]        w_case_ext;
  logic               w_req_legal;
  logic [SEL_W-1:0]   w_req_sel;
  logic [7:0]         w_lut_len;
  logic [7:0]         w_lut_stage;
  logic [LEN_W-1:0]   w_eff_len;
  logic [GAP_W-1:0]   w_eff_stage;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_hs;

  logic               w_load;
  logic [SEL_W-1:0]   w_ld_case;
  logic [IDX_W-1:0]   w_ld_idx;
  logic [LEN_W-1:0]   w_ld_len;
  logic [TAG_W-1:0]   w_ld_tag;
  logic               w_ld_last;

  // Illegal ids are steered to entry 0 so the tables are never indexed out of range.
  assign w_case_ext  = 32'(bus.req_case_id);
  assign w_req_legal = (w_case_ext < 32'(N_CASE));
  assign w_req_sel   = w_req_legal ? SEL_W'(bus.req_case_id) : '0;
  assign w_lut_len   = LEN_LUT[w_req_sel];
  assign w_lut_stage = STAGE_TAB[w_req_sel];
  assign w_eff_len   = (w_lut_len > 8'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN_W'(w_lut_len);
  assign w_eff_stage = (w_lut_stage == 8'd0) ? 8'd1 : w_lut_stage;

  assign w_req_ready = (r_state == S_IDLE) && !flush;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_hs        = (r_state == S_ISSUE) && bus.uop_ready;

  // Selects which uop (case, index) gets registered onto the output this cycle.
  always_comb begin
    w_ld_case = r_case;
    w_ld_idx  = r_idx + IDX_W'(1);
    w_ld_len  = r_len;
    w_ld_tag  = r_tag;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ld_case = w_req_sel;
        w_ld_idx  = '0;
        w_ld_len  = w_eff_len;
        w_ld_tag  = bus.req_tag;
        w_load    = w_accept && w_req_legal && (w_eff_len != '0);
      end
      S_ISSUE: w_load = w_hs && !r_uop_last && (r_stage == 8'd1) && !flush;
      S_GAP: begin
        w_ld_idx = r_idx;
        w_load   = (r_gap == 8'd1) && !flush;
      end
      default: w_load = 1'b0;
    endcase
  end

  assign w_ld_last = ({1'b0, w_ld_idx} == (w_ld_len - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_case        <= '0;
      r_tag         <= '0;
      r_len         <= '0;
      r_stage       <= 8'd1;
      r_gap         <= '0;
      r_idx         <= '0;
      r_uop_valid   <= 1'b0;
      r_uop_op      <= OP_NOP;
      r_uop_imm     <= '0;
      r_uop_use_imm <= 1'b0;
      r_uop_fwd     <= 1'b0;
      r_uop_idx     <= '0;
      r_uop_last    <= 1'b0;
      r_uop_tag     <= '0;
      r_done_valid  <= 1'b0;
      r_done_err    <= 1'b0;
      r_done_tag    <= '0;
    end else begin
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
      if (flush) begin
        r_state     <= S_IDLE;
        r_uop_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_case  <= w_req_sel;
              r_tag   <= bus.req_tag;
              r_len   <= w_eff_len;
              r_stage <= w_eff_stage;
              r_idx   <= '0;
              if (!w_req_legal) begin
                r_done_valid <= 1'b1;
                r_done_err   <= 1'b1;
                r_done_tag   <= bus.req_tag;
              end else if (w_eff_len == '0) begin
                r_done_valid <= 1'b1;
                r_done_tag   <= bus.req_tag;
              end else begin
                r_state <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            if (w_hs) begin
              if (r_uop_last) begin
                r_state      <= S_IDLE;
                r_uop_valid  <= 1'b0;
                r_done_valid <= 1'b1;
                r_done_tag   <= r_tag;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
                if (r_stage != 8'd1) begin
                  r_gap       <= r_stage - 8'd1;
                  r_state     <= S_GAP;
                  r_uop_valid <= 1'b0;
                end
              end
            end
          end
          S_GAP: begin
            r_gap <= r_gap - 8'd1;
            if (r_gap == 8'd1) r_state <= S_ISSUE;
          end
          default: r_state <= S_IDLE;
        endcase

        if (w_load) begin
          r_uop_valid   <= 1'b1;
          r_uop_op      <= OPS_LUT[w_ld_case][w_ld_idx];
          r_uop_imm     <= IMM_LUT[w_ld_case][w_ld_idx];
          r_uop_use_imm <= USE_IMM_LUT[w_ld_case][w_ld_idx];
          r_uop_fwd     <= FF_MASK_LUT[w_ld_case][w_ld_idx];
          r_uop_idx     <= w_ld_idx;
          r_uop_last    <= w_ld_last;
          r_uop_tag     <= w_ld_tag;
        end
      end
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.uop_valid   = r_uop_valid;
  assign bus.uop_op      = r_uop_op;
  assign bus.uop_imm     = r_uop_imm;
  assign bus.uop_use_imm = r_uop_use_imm;
  assign bus.uop_fwd     = r_uop_fwd;
  assign bus.uop_idx     = r_uop_idx;
  assign bus.uop_last    = r_uop_last;
  assign bus.uop_tag     = r_uop_tag;
  assign bus.done_valid  = r_done_valid;
  assign bus.done_err    = r_done_err;
  assign bus.done_tag    = r_done_tag;

endmodule

`default_nettype wire
